// File: rtl/fft_apb_master_if.sv
// rtl/fft_apb_master_if.sv - command, APB and response signal bundle for fft_apb_master
interface fft_apb_master_if #(
    parameter int APB_ADDR_WIDTH = 16
);
    logic                      cmd_valid_i;
    logic                      cmd_ready_o;
    logic                      cmd_write_i;
    logic                      cmd_poll_i;
    logic [APB_ADDR_WIDTH-1:0] cmd_addr_i;
    logic [31:0]               cmd_wdata_i;
    logic [31:0]               cmd_mask_i;

    logic                      psel_o;
    logic                      penable_o;
    logic                      pwrite_o;
    logic [APB_ADDR_WIDTH-1:0] paddr_o;
    logic [31:0]               pwdata_o;
    logic [31:0]               prdata_i;
    logic                      pready_i;

    logic                      rsp_valid_o;
    logic [31:0]               rsp_rdata_o;
    logic                      rsp_error_o;
    logic                      busy_o;

    modport master (
        input  cmd_valid_i, cmd_write_i, cmd_poll_i, cmd_addr_i, cmd_wdata_i, cmd_mask_i,
        input  prdata_i, pready_i,
        output cmd_ready_o, psel_o, penable_o, pwrite_o, paddr_o, pwdata_o,
        output rsp_valid_o, rsp_rdata_o, rsp_error_o, busy_o
    );

    modport slave (
        output cmd_valid_i, cmd_write_i, cmd_poll_i, cmd_addr_i, cmd_wdata_i, cmd_mask_i,
        output prdata_i, pready_i,
        input  cmd_ready_o, psel_o, penable_o, pwrite_o, paddr_o, pwdata_o,
        input  rsp_valid_o, rsp_rdata_o, rsp_error_o, busy_o
    );
endinterface

// File: rtl/fft_apb_master.sv
// rtl/fft_apb_master.sv - APB master running single write/read or masked read-poll commands
module fft_apb_master #(
    parameter int APB_ADDR_WIDTH = 16,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int POLL_MAX       = 1024,
    parameter int POLL_GAP       = 4
) (
    input  logic              clk_i,
    input  logic              reset_i,
    fft_apb_master_if.master  bus
);
    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ACCESS, S_GAP, S_RESP} state_t;

    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);
    localparam logic [15:0] POLL_LIM    = 16'(POLL_MAX);
    // A zero gap still costs one idle cycle between poll reads.
    localparam logic [15:0] GAP_LIM     = (POLL_GAP == 0) ? 16'd1 : 16'(POLL_GAP);

    state_t                    state_q, state_d;
    logic                      poll_q, poll_d;
    logic                      pwrite_q, pwrite_d;
    logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [31:0]               pwdata_q, pwdata_d;
    logic [31:0]               mask_q, mask_d;
    logic [15:0]               wait_cnt_q, wait_cnt_d;
    logic [15:0]               poll_cnt_q, poll_cnt_d;
    logic [15:0]               gap_cnt_q, gap_cnt_d;
    logic                      psel_q, psel_d;
    logic                      penable_q, penable_d;
    logic                      cmd_ready_q, cmd_ready_d;
    logic                      rsp_valid_q, rsp_valid_d;
    logic                      rsp_error_q, rsp_error_d;
    logic                      busy_q, busy_d;
    logic [31:0]               rsp_rdata_q, rsp_rdata_d;

    logic [15:0] wait_inc, poll_inc, gap_inc;
    logic        poll_match;

    assign wait_inc   = (wait_cnt_q == 16'hFFFF) ? wait_cnt_q : wait_cnt_q + 16'd1;
    assign poll_inc   = (poll_cnt_q == 16'hFFFF) ? poll_cnt_q : poll_cnt_q + 16'd1;
    assign gap_inc    = (gap_cnt_q  == 16'hFFFF) ? gap_cnt_q  : gap_cnt_q  + 16'd1;
    assign poll_match = ((bus.prdata_i ^ pwdata_q) & mask_q) == 32'd0;

    always_comb begin
        state_d     = state_q;
        poll_d      = poll_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        mask_d      = mask_q;
        wait_cnt_d  = wait_cnt_q;
        poll_cnt_d  = poll_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        rsp_error_d = rsp_error_q;
        rsp_rdata_d = rsp_rdata_q;

        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid_i) begin
                    poll_d     = bus.cmd_poll_i;
                    pwrite_d   = bus.cmd_write_i & ~bus.cmd_poll_i;
                    paddr_d    = bus.cmd_addr_i;
                    pwdata_d   = bus.cmd_wdata_i;
                    mask_d     = bus.cmd_mask_i;
                    poll_cnt_d = 16'd0;
                    state_d    = S_SETUP;
                end
            end
            S_SETUP: begin
                wait_cnt_d = 16'd0;
                state_d    = S_ACCESS;
            end
            S_ACCESS: begin
                // pready wins over a timeout landing in the same cycle.
                if (bus.pready_i) begin
                    if (!pwrite_q) begin
                        rsp_rdata_d = bus.prdata_i;
                    end
                    if (!poll_q || poll_match) begin
                        rsp_error_d = 1'b0;
                        state_d     = S_RESP;
                    end else begin
                        poll_cnt_d = poll_inc;
                        if (poll_inc >= POLL_LIM) begin
                            rsp_error_d = 1'b1;
                            state_d     = S_RESP;
                        end else begin
                            gap_cnt_d = 16'd0;
                            state_d   = S_GAP;
                        end
                    end
                end else begin
                    wait_cnt_d = wait_inc;
                    if (wait_inc >= TIMEOUT_LIM) begin
                        rsp_error_d = 1'b1;
                        state_d     = S_RESP;
                    end
                end
            end
            S_GAP: begin
                gap_cnt_d = gap_inc;
                if (gap_inc >= GAP_LIM) begin
                    state_d = S_SETUP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        psel_d      = (state_d == S_SETUP) || (state_d == S_ACCESS);
        penable_d   = (state_d == S_ACCESS);
        rsp_valid_d = (state_d == S_RESP);
        busy_d      = (state_d != S_IDLE);
        cmd_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            poll_q      <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= 32'd0;
            mask_q      <= 32'd0;
            wait_cnt_q  <= 16'd0;
            poll_cnt_q  <= 16'd0;
            gap_cnt_q   <= 16'd0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            busy_q      <= 1'b0;
            rsp_rdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            poll_q      <= poll_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            mask_q      <= mask_d;
            wait_cnt_q  <= wait_cnt_d;
            poll_cnt_q  <= poll_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_error_q <= rsp_error_d;
            busy_q      <= busy_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign bus.cmd_ready_o = cmd_ready_q;
    assign bus.psel_o      = psel_q;
    assign bus.penable_o   = penable_q;
    assign bus.pwrite_o    = pwrite_q;
    assign bus.paddr_o     = paddr_q;
    assign bus.pwdata_o    = pwdata_q;
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_error_o = rsp_error_q;
    assign bus.rsp_rdata_o = rsp_rdata_q;
    assign bus.busy_o      = busy_q;
endmodule

// File: doc/fft_apb_master.md
FFT_APB_MASTER -- requirements
Module: fft_apb_master

Interface
REQ-001 The block SHALL have parameter APB_ADDR_WIDTH, default 16, APB address width.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 255, the maximum number of ACCESS cycles with pready_i low before an abort (range 1..65535).
REQ-003 The block SHALL have parameter POLL_MAX, default 1024, the maximum number of read attempts per poll command (range 1..65535).
REQ-004 The block SHALL have parameter POLL_GAP, default 4, the number of idle cycles between poll attempts (range 0..255).
REQ-005 The block SHALL have these ports (name, direction, width, meaning):
- clk_i  in  1  system clock; APB runs synchronously on it.
- reset_i  in  1  asynchronous, active-high reset.
- cmd_valid_i  in  1  command request.
- cmd_ready_o  out  1  command accepted when high together with cmd_valid_i.
- cmd_write_i  in  1  1 = write, 0 = read.
- cmd_poll_i  in  1  read-poll command; cmd_write_i is ignored when this is set.
- cmd_addr_i  in  APB_ADDR_WIDTH  target register address.
- cmd_wdata_i  in  32  write data, or the poll compare value.
- cmd_mask_i  in  32  poll compare mask.
- psel_o, penable_o, pwrite_o  out  1 each  APB control.
- paddr_o  out  APB_ADDR_WIDTH  APB address.
- pwdata_o  out  32  APB write data.
- prdata_i  in  32  APB read data.
- pready_i  in  1  APB ready.
- rsp_valid_o  out  1  one-cycle completion pulse.
- rsp_rdata_o  out  32  last read data.
- rsp_error_o  out  1  timeout or poll exhaustion; valid with rsp_valid_o.
- busy_o  out  1  high in every state except IDLE.

Function
REQ-006 The FSM SHALL have the states IDLE, SETUP, ACCESS, GAP and RESP; all outputs SHALL be registered.
REQ-007 cmd_ready_o SHALL be 1 only in IDLE.
- On cmd_valid_i & cmd_ready_o, the block SHALL latch write, poll, addr, wdata and mask, clear the poll counter, and go to SETUP.
REQ-008 SETUP SHALL drive psel_o=1, penable_o=0, and paddr_o/pwrite_o/pwdata_o from the latched command; the block SHALL go to ACCESS after 1 cycle.
- pwrite_o SHALL be 0 for poll commands.
REQ-009 ACCESS SHALL drive psel_o=1, penable_o=1, with address, data and control held stable.
- The block SHALL remain in ACCESS while pready_i=0.
REQ-010 On pready_i=1 in ACCESS:
- For a read or poll, the block SHALL capture prdata_i into rsp_rdata_o.
- psel_o and penable_o SHALL be 0 in the following cycle.
REQ-011 A write or plain read that completes in ACCESS SHALL go to RESP with rsp_error_o=0.
REQ-012 A poll that completes in ACCESS SHALL behave as follows:
- Match, (prdata_i & mask) == (wdata & mask): go to RESP, error=0.
- Mismatch: increment the poll counter; if the count equals POLL_MAX, go to RESP with error=1; otherwise go to GAP.
REQ-013 GAP SHALL hold psel_o=0 for POLL_GAP cycles, then go to SETUP; with POLL_GAP=0 it SHALL go straight to SETUP, giving 1 idle cycle.
REQ-014 The wait counter SHALL clear on SETUP and increment for each ACCESS cycle with pready_i=0.
- When it reaches TIMEOUT_CYCLES, the block SHALL deassert psel_o/penable_o next cycle, go to RESP with error=1, and leave rsp_rdata_o unchanged.
- pready_i arriving in the same cycle as the limit SHALL take priority; that is a normal completion.
REQ-015 RESP SHALL assert rsp_valid_o for exactly 1 cycle, then go to IDLE; rsp_error_o and rsp_rdata_o SHALL hold until the next RESP.
REQ-016 Latency: with zero wait states, rsp_valid_o SHALL rise 3 cycles after the accept edge (SETUP, ACCESS, RESP); back-to-back commands SHALL have a 1-cycle IDLE gap.
REQ-017 Counters SHALL be 16 bits wide and saturating; a poll SHALL never issue more than POLL_MAX reads.
REQ-018 The block SHALL ignore pready_i and prdata_i outside ACCESS.

Reset
REQ-019 Asserting reset_i SHALL immediately force IDLE, with psel_o, penable_o, pwrite_o, rsp_valid_o, rsp_error_o and busy_o = 0, paddr_o, pwdata_o and rsp_rdata_o = 0, and all counters = 0.
REQ-020 Reset asserted mid-transfer SHALL abort it with no response; the first command after release SHALL start a clean SETUP.

Verification
REQ-021 Write addr 0x0004, data 0x0000_0001, pready_i tied 1 -> SETUP then ACCESS with pwrite_o=1, paddr_o=0x0004, pwdata_o=1; rsp_valid_o 3 cycles after accept; error=0.
REQ-022 Read 0x0010 with pready_i low for 5 cycles, prdata_i=0xDEAD_BEEF -> ACCESS lasts 6 cycles; rsp_rdata_o=0xDEADBEEF; error=0.
REQ-023 Poll 0x0008, mask 0x2, value 0x2; slave returns 0, 0, 0x2 -> 3 APB reads, each separated by POLL_GAP idle cycles; rsp_rdata_o=0x2; error=0.
REQ-024 Poll with POLL_MAX=4 and a never-matching slave -> exactly 4 reads; rsp_error_o=1.
REQ-025 TIMEOUT_CYCLES=8 with pready_i stuck 0 -> psel_o drops after 8 ACCESS cycles; rsp_error_o=1; the next command succeeds.
REQ-026 reset_i pulsed during ACCESS -> psel_o/penable_o go to 0 asynchronously; no rsp_valid_o; cmd_ready_o=1 after release.
